instr_decode_pipe: RTL and testbench
====================================

Name: instr_decode_pipe

Overview:
- Registered, parametrised successor to the combinational instruction decoder.
- Accepts 32-bit instruction words over a valid/ready handshake and decodes each into an instruction ID, register fields, a sign-extended immediate and a jump target.
- Buffers results in a DEPTH-entry queue so fetch and execute can stall independently.
- Sits between the fetch stage and the register-read/execute stage.

Parameters:
- INSTR_W, 32: instruction width; opcode is always the top 6 bits.
- REG_W, 5: register-index field width.
- ID_W, 4: width of the decoded instruction ID.
- DEPTH, 2: queue entries; must be a power of two and ≥2.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous clear of all queued entries.
- in_valid  input  1  ir is valid.
- in_ready  output  1  queue can accept; equals !full and is registered.
- ir  input  INSTR_W  instruction word.
- out_valid  output  1  head entry valid; equals !empty.
- out_ready  input  1  consumer takes the head entry.
- ID  output  ID_W  decoded instruction ID.
- rs  output  REG_W  ir[25:21].
- rt  output  REG_W  ir[20:16].
- rd  output  REG_W  ir[15:11] for R-type; 0 otherwise.
- imm  output  INSTR_W  sign-extended ir[15:0] for I-type; 0 otherwise.
- jtarget  output  26  ir[25:0] for j; 0 otherwise.
- illegal  output  1  opcode not in the decode map.
- stat_decoded  output  32  popped-instruction count (optional feature).
- stat_illegal  output  32  popped-illegal count (optional feature).

Behaviour:
- Opcode map (opcode → ID):
  - R-type: 000000 add=1, 000011 and=3, 010011 slt=6.
  - I-type: 000001 addi=2, 000110 ori=5, 001000 lw=7, 001001 sw=8.
  - J-type: 010000 j=4.
  - Any other opcode: ID=0, illegal=1, and rs/rt/rd/imm/jtarget are all 0.
- Decode is combinational on ir; the full decoded record is written into the queue at the tail.
- Push when in_valid && in_ready && !flush. Pop when out_valid && out_ready && !flush.
- Outputs always show the head entry. When empty, ID, fields, imm, jtarget and illegal are all 0.
- Latency: a word pushed at edge N is visible with out_valid=1 after edge N (one cycle), provided the queue was empty.
- Simultaneous push and pop (not full, not empty): count is unchanged; FIFO order is preserved.
- Full: in_ready=0 regardless of out_ready. There is no combinational path from out_ready to in_ready. A pop while full raises in_ready on the next cycle.
- Empty: out_valid=0; out_ready is ignored.
- Read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH. Count is log2(DEPTH)+1 bits.
- flush:
  - Pointers and count go to 0 at the edge; in_valid is ignored that cycle.
  - Takes priority over push and pop.
  - Stat counters are not affected.
- Reset asserted (low), including mid-transfer:
  - Immediately: pointers and count = 0, out_valid=0, all decoded outputs 0, stats 0.
  - in_ready=1 from the first edge after reset deasserts.
  - Entries in flight are discarded.
- Held outputs: while out_valid=1 and out_ready=0, the head entry must stay stable.

Optional Feature:
- Macro: DECODE_STATS_EN.
- Defined: stat_decoded increments on every pop. stat_illegal increments on every pop whose head has illegal=1. Both are 32-bit wrapping counters, cleared only by reset.
- Undefined: the ports remain but are tied to 0 and no counter logic is generated.

Test Plan:
- Single push with out_ready=1, ir=000000_00011_00101_00001_00000_000000 → one cycle later out_valid=1, ID=1, rs=3, rt=5, rd=1, imm=0, illegal=0.
- Push addi $1,$2,100, then 001000 with imm=0xFFFC (lw) → ID=2, rs=2, rt=1, imm=100; then ID=7, imm=0xFFFFFFFC.
- j 100 (010000_…_1100100) → ID=4, jtarget=100, rd=0, imm=0. Opcode 111111 → ID=0, illegal=1.
- Hold out_ready=0 and push DEPTH words → in_ready=0 after the DEPTH-th push, head unchanged. Then push and pop streaming for 20 cycles → output order matches input order across pointer wrap.
- With 2 entries queued, assert flush together with in_valid=1 → next cycle out_valid=0, count=0, in_ready=1, and the flushed word never appears.
- DECODE_STATS_EN defined: pop 5 legal and 2 illegal words → stat_decoded=7, stat_illegal=2. Pulse reset low mid-stream → all outputs 0 asynchronously.

Source files
------------

// File: rtl/instr_decode_pipe.sv
// rtl/instr_decode_pipe.sv - registered instruction decoder with a DEPTH-entry result queue
// Optional pop statistics are enabled with the DECODE_STATS_EN macro.
module instr_decode_pipe #(
  parameter int INSTR_W = 32,
  parameter int REG_W   = 5,
  parameter int ID_W    = 4,
  parameter int DEPTH   = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] ir,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ID_W-1:0]    ID,
  output logic [REG_W-1:0]   rs,
  output logic [REG_W-1:0]   rt,
  output logic [REG_W-1:0]   rd,
  output logic [INSTR_W-1:0] imm,
  output logic [25:0]        jtarget,
  output logic               illegal,
  output logic [31:0]        stat_decoded,
  output logic [31:0]        stat_illegal
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef struct packed {
    logic [ID_W-1:0]    id;
    logic [REG_W-1:0]   rs;
    logic [REG_W-1:0]   rt;
    logic [REG_W-1:0]   rd;
    logic [INSTR_W-1:0] imm;
    logic [25:0]        jt;
    logic               ill;
  } rec_t;

  rec_t            w_dec;
  rec_t            w_head;
  rec_t            r_mem [DEPTH];
  logic [5:0]      w_op;
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [AW:0]     r_count;
  logic [AW:0]     w_count_nxt;
  logic            r_in_ready;
  logic            w_empty;
  logic            w_push;
  logic            w_pop;

  assign w_op = ir[INSTR_W-1 -: 6];

  always_comb begin
    w_dec    = '0;
    w_dec.rs = ir[21 +: REG_W];
    w_dec.rt = ir[16 +: REG_W];
    case (w_op)
      6'b000000: begin w_dec.id = ID_W'(1); w_dec.rd = ir[11 +: REG_W]; end
      6'b000011: begin w_dec.id = ID_W'(3); w_dec.rd = ir[11 +: REG_W]; end
      6'b010011: begin w_dec.id = ID_W'(6); w_dec.rd = ir[11 +: REG_W]; end
      6'b000001: begin w_dec.id = ID_W'(2); w_dec.imm = {{(INSTR_W-16){ir[15]}}, ir[15:0]}; end
      6'b000110: begin w_dec.id = ID_W'(5); w_dec.imm = {{(INSTR_W-16){ir[15]}}, ir[15:0]}; end
      6'b001000: begin w_dec.id = ID_W'(7); w_dec.imm = {{(INSTR_W-16){ir[15]}}, ir[15:0]}; end
      6'b001001: begin w_dec.id = ID_W'(8); w_dec.imm = {{(INSTR_W-16){ir[15]}}, ir[15:0]}; end
      6'b010000: begin w_dec.id = ID_W'(4); w_dec.jt = ir[25:0]; end
      default: begin
        w_dec     = '0;
        w_dec.ill = 1'b1;
      end
    endcase
  end

  assign w_empty   = (r_count == '0);
  assign w_push    = in_valid && r_in_ready && !flush;
  assign w_pop     = !w_empty && out_ready && !flush;
  assign w_head    = r_mem[r_rd_ptr];

  always_comb begin
    w_count_nxt = r_count;
    if (flush) begin
      w_count_nxt = '0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   w_count_nxt = r_count + (AW+1)'(1);
        2'b01:   w_count_nxt = r_count - (AW+1)'(1);
        default: w_count_nxt = r_count;
      endcase
    end
  end

  // in_ready is derived from the next count so it is a pure flop with no out_ready path
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_in_ready <= 1'b0;
    end else begin
      r_count    <= w_count_nxt;
      r_in_ready <= (w_count_nxt != FULL_CNT);
      if (flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_dec;
  end

  assign in_ready  = r_in_ready;
  assign out_valid = !w_empty;
  assign ID        = w_empty ? '0 : w_head.id;
  assign rs        = w_empty ? '0 : w_head.rs;
  assign rt        = w_empty ? '0 : w_head.rt;
  assign rd        = w_empty ? '0 : w_head.rd;
  assign imm       = w_empty ? '0 : w_head.imm;
  assign jtarget   = w_empty ? '0 : w_head.jt;
  assign illegal   = w_empty ? 1'b0 : w_head.ill;

`ifdef DECODE_STATS_EN
  logic [31:0] r_stat_decoded;
  logic [31:0] r_stat_illegal;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stat_decoded <= '0;
      r_stat_illegal <= '0;
    end else if (w_pop) begin
      r_stat_decoded <= r_stat_decoded + 32'd1;
      if (w_head.ill) r_stat_illegal <= r_stat_illegal + 32'd1;
    end
  end

  assign stat_decoded = r_stat_decoded;
  assign stat_illegal = r_stat_illegal;
`else
  assign stat_decoded = '0;
  assign stat_illegal = '0;
`endif

endmodule

// File: tb/tb_instr_decode_pipe.sv
// tb/tb_instr_decode_pipe.sv - directed self-checking bench for instr_decode_pipe
// Stats checks switch on DECODE_STATS_EN.
module tb_instr_decode_pipe;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] ir = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [3:0]  ID;
  logic [4:0]  rs, rt, rd;
  logic [31:0] imm;
  logic [25:0] jtarget;
  logic        illegal;
  logic [31:0] stat_decoded, stat_illegal;

  int total = 0;
  int bad = 0;

  instr_decode_pipe #(.INSTR_W(32), .REG_W(5), .ID_W(4), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .ir(ir),
    .out_valid(out_valid), .out_ready(out_ready),
    .ID(ID), .rs(rs), .rt(rt), .rd(rd), .imm(imm), .jtarget(jtarget), .illegal(illegal),
    .stat_decoded(stat_decoded), .stat_illegal(stat_illegal)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (2) step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0b want=0", out_valid); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%0b want=0", in_ready); end
    total++; if (ID !== 4'd0 || illegal !== 1'b0 || imm !== 32'd0) begin bad++; $display("FAIL reset_fields got ID=%0d ill=%0b imm=%h want 0", ID, illegal, imm); end
    reset = 1'b1;
    step();
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL post_reset_in_ready got=%0b want=1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL post_reset_out_valid got=%0b want=0", out_valid); end
  endtask

  task automatic test_rtype;
    out_ready = 1'b1;
    in_valid = 1'b1;
    ir = {6'b000000, 5'd3, 5'd5, 5'd1, 5'd0, 6'd0};
    step();
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL rtype_valid got=%0b want=1", out_valid); end
    total++; if (ID !== 4'd1 || rs !== 5'd3 || rt !== 5'd5 || rd !== 5'd1) begin bad++; $display("FAIL rtype_fields got ID=%0d rs=%0d rt=%0d rd=%0d want 1/3/5/1", ID, rs, rt, rd); end
    total++; if (imm !== 32'd0 || illegal !== 1'b0 || jtarget !== 26'd0) begin bad++; $display("FAIL rtype_zero got imm=%h ill=%0b jt=%h want 0", imm, illegal, jtarget); end
    step();
    total++; if (out_valid !== 1'b0 || ID !== 4'd0) begin bad++; $display("FAIL rtype_drain got valid=%0b ID=%0d want 0/0", out_valid, ID); end
  endtask

  task automatic test_itype;
    out_ready = 1'b0;
    in_valid = 1'b1;
    ir = {6'b000001, 5'd2, 5'd1, 16'd100};
    step();
    ir = {6'b001000, 5'd4, 5'd6, 16'hFFFC};
    step();
    in_valid = 1'b0;
    total++; if (ID !== 4'd2 || rs !== 5'd2 || rt !== 5'd1 || imm !== 32'd100 || rd !== 5'd0) begin bad++; $display("FAIL addi got ID=%0d rs=%0d rt=%0d imm=%h rd=%0d want 2/2/1/64/0", ID, rs, rt, imm, rd); end
    out_ready = 1'b1;
    step();
    total++; if (ID !== 4'd7 || imm !== 32'hFFFFFFFC || rs !== 5'd4 || rt !== 5'd6) begin bad++; $display("FAIL lw got ID=%0d imm=%h rs=%0d rt=%0d want 7/fffffffc/4/6", ID, imm, rs, rt); end
    step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL itype_drain got=%0b want=0", out_valid); end
  endtask

  task automatic test_jtype_illegal;
    out_ready = 1'b0;
    in_valid = 1'b1;
    ir = {6'b010000, 26'd100};
    step();
    ir = {6'b111111, 26'h3FFFFFF};
    step();
    in_valid = 1'b0;
    total++; if (ID !== 4'd4 || jtarget !== 26'd100 || rd !== 5'd0 || imm !== 32'd0 || illegal !== 1'b0) begin bad++; $display("FAIL j got ID=%0d jt=%0d rd=%0d imm=%h ill=%0b want 4/100/0/0/0", ID, jtarget, rd, imm, illegal); end
    out_ready = 1'b1;
    step();
    total++; if (out_valid !== 1'b1 || ID !== 4'd0 || illegal !== 1'b1) begin bad++; $display("FAIL illegal_id got valid=%0b ID=%0d ill=%0b want 1/0/1", out_valid, ID, illegal); end
    total++; if (rs !== 5'd0 || rt !== 5'd0 || rd !== 5'd0 || imm !== 32'd0 || jtarget !== 26'd0) begin bad++; $display("FAIL illegal_fields got rs=%0d rt=%0d rd=%0d imm=%h jt=%h want 0", rs, rt, rd, imm, jtarget); end
    step();
  endtask

  task automatic test_full;
    out_ready = 1'b0;
    in_valid = 1'b1;
    for (int k = 0; k < DEPTH; k++) begin
      ir = {6'b000011, 5'(k + 10), 5'd0, 5'd0, 11'd0};
      step();
    end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL full_in_ready got=%0b want=0", in_ready); end
    ir = {6'b000011, 5'd30, 5'd0, 5'd0, 11'd0};
    repeat (2) step();
    total++; if (ID !== 4'd3 || rs !== 5'd10 || in_ready !== 1'b0) begin bad++; $display("FAIL full_hold got ID=%0d rs=%0d rdy=%0b want 3/10/0", ID, rs, in_ready); end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    total++; if (in_ready !== 1'b1 || rs !== 5'd11) begin bad++; $display("FAIL full_pop got rdy=%0b rs=%0d want 1/11", in_ready, rs); end
    step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL full_drain got=%0b want=0", out_valid); end
  endtask

  task automatic test_stream;
    int exp_q[$];
    int sent = 0;
    int got = 0;
    int cyc = 0;
    logic do_push, do_pop;
    logic [4:0] e;
    while (got < 20 && cyc < 200) begin
      out_ready = (cyc % 3 != 2);
      in_valid = (sent < 20);
      ir = {6'b000000, 5'(sent), 5'(~sent), 5'(sent + 1), 11'd0};
      #1;
      do_push = in_valid && in_ready;
      do_pop = out_valid && out_ready;
      if (out_valid) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL stream_spurious got rs=%0d want no entry", rs);
        end else begin
          e = 5'(exp_q[0]);
          if (rs !== e || rt !== ~e || rd !== e + 5'd1) begin bad++; $display("FAIL stream_order got rs=%0d rt=%0d rd=%0d want %0d/%0d/%0d", rs, rt, rd, e, ~e, e + 5'd1); end
        end
      end
      step();
      if (do_push) begin exp_q.push_back(sent); sent++; end
      if (do_pop) begin if (exp_q.size() > 0) void'(exp_q.pop_front()); got++; end
      cyc++;
    end
    in_valid = 1'b0;
    total++; if (got != 20) begin bad++; $display("FAIL stream_timeout got=%0d want=20", got); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stream_empty got=%0b want=0", out_valid); end
  endtask

  task automatic test_flush;
    out_ready = 1'b0;
    in_valid = 1'b1;
    ir = {6'b000110, 5'd1, 5'd2, 16'd7};
    step();
    ir = {6'b000110, 5'd3, 5'd4, 16'd8};
    step();
    flush = 1'b1;
    ir = {6'b001001, 5'd9, 5'd9, 16'd9};
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || ID !== 4'd0) begin bad++; $display("FAIL flush_full got valid=%0b rdy=%0b ID=%0d want 0/1/0", out_valid, in_ready, ID); end
    in_valid = 1'b1;
    ir = {6'b000110, 5'd5, 5'd6, 16'd1};
    step();
    flush = 1'b1;
    ir = {6'b001001, 5'd9, 5'd9, 16'd9};
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    repeat (2) step();
    total++; if (out_valid !== 1'b0 || ID !== 4'd0) begin bad++; $display("FAIL flush_push_blocked got valid=%0b ID=%0d want 0/0", out_valid, ID); end
  endtask

  task automatic test_stats_and_async_reset;
    reset = 1'b0;
    step();
    reset = 1'b1;
    step();
    out_ready = 1'b1;
    in_valid = 1'b1;
    for (int k = 0; k < 7; k++) begin
      ir = (k == 2 || k == 5) ? {6'b111110, 26'd0} : {6'b001001, 5'(k), 5'd1, 16'd4};
      step();
    end
    in_valid = 1'b0;
    step();
`ifdef DECODE_STATS_EN
    total++; if (stat_decoded !== 32'd7) begin bad++; $display("FAIL stat_decoded got=%0d want=7", stat_decoded); end
    total++; if (stat_illegal !== 32'd2) begin bad++; $display("FAIL stat_illegal got=%0d want=2", stat_illegal); end
`else
    total++; if (stat_decoded !== 32'd0 || stat_illegal !== 32'd0) begin bad++; $display("FAIL stat_tied got=%0d/%0d want 0/0", stat_decoded, stat_illegal); end
`endif
    out_ready = 1'b0;
    in_valid = 1'b1;
    ir = {6'b000001, 5'd7, 5'd8, 16'h8000};
    repeat (2) step();
    in_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0 || ID !== 4'd0 || rs !== 5'd0 || imm !== 32'd0) begin bad++; $display("FAIL async_reset got valid=%0b ID=%0d rs=%0d imm=%h want 0", out_valid, ID, rs, imm); end
    total++; if (stat_decoded !== 32'd0 || stat_illegal !== 32'd0) begin bad++; $display("FAIL async_reset_stats got=%0d/%0d want 0/0", stat_decoded, stat_illegal); end
    step();
    reset = 1'b1;
    step();
    total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL reset_release got rdy=%0b valid=%0b want 1/0", in_ready, out_valid); end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_itype();
    test_jtype_illegal();
    test_full();
    test_stream();
    test_flush();
    test_stats_and_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
